tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-lane time-division demultiplexer: takes a single time-multiplexed beat stream (one lane per slot, slot 0 flagged by a start-of-frame marker) and distributes it back onto four parallel lane registers. It is the receive-side counterpart of the team's 4:1 lane multiplexer. A complete frame is presented as one valid word across all four lanes with a valid/ready handshake. Partial and misaligned frames are detected and discarded.

## Interface
- `WIDTH`, default 8: lane data width in bits.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input beat present.
- `in_sof` input 1: qualifies the current beat as slot 0 (lane 0) of a frame; ignored when `in_valid`=0.
- `in_data` input WIDTH: beat payload.
- `in_ready` output 1: the beat is accepted on the edge where `in_valid && in_ready`.
- `out_lane0`..`out_lane3` output WIDTH each: registered lane payloads of the last completed frame.
- `out_valid` output 1: the lane registers hold an unconsumed frame.
- `out_ready` input 1: the frame is consumed on the edge where `out_valid && out_ready`.
- `frame_err` output 1: one-cycle pulse; a partial frame was aborted by an early `in_sof`.
- `drop` output 1: one-cycle pulse; a beat without `in_sof` was accepted and discarded while hunting.

## Operation
- Two states: HUNT (waiting for slot 0) and COLLECT (slots 1..3 pending). A 2-bit slot counter holds the next expected slot.
- HUNT, accepted beat with `in_sof`=1: store into staging lane 0, slot:=1, go to COLLECT.
- HUNT, accepted beat with `in_sof`=0: discard it, pulse `drop`, stay in HUNT.
- COLLECT, accepted beat with `in_sof`=0 and slot 1 or 2: store into staging lane[slot], slot:=slot+1.
- COLLECT, accepted beat with `in_sof`=0 and slot 3: frame complete. Staging lanes 0..2 plus the current `in_data` (lane 3) load into `out_lane0..3` and `out_valid`:=1. Slot:=0, go to HUNT. The next frame must start with `in_sof`.
- COLLECT, accepted beat with `in_sof`=1 (any slot 1..3): pulse `frame_err`, discard the partial frame, and treat the beat as slot 0 of a new frame (staging lane 0, slot:=1, stay in COLLECT). The output registers are not touched.
- `in_ready`=0 only when state=COLLECT, slot=3, `out_valid`=1 and `out_ready`=0. In all other cases it is 1. It is combinational from state and output handshake, with no dependence on `in_valid`.
- Consume (`out_valid && out_ready`) without a simultaneous completion: `out_valid`:=0. The lane registers keep their values.
- Consume and completion on the same edge: the new frame loads and `out_valid` stays 1.
- Lane registers change only on frame completion. Staging registers are not visible on ports.

## Timing
- Reset (asynchronous assert, `rst_n`=0): state=HUNT, slot=0, staging and `out_lane0..3`=0, `out_valid`=0, `frame_err`=0, `drop`=0. `in_ready`=1 during and after reset.
- Reset mid-frame discards the partial frame and any unconsumed output frame. No `frame_err` is raised.
- Latency: the slot-3 beat accepted on edge k gives `out_valid`=1 and new lane data from edge k until consumed.
- Throughput: with `out_ready` held at 1, one beat per cycle is sustained, which is one frame per 4 cycles, back-to-back with no bubbles.
- Backpressure stalls only the slot-3 beat. Slots 0..2 are always accepted.
- `frame_err` and `drop` are registered pulses, asserted for exactly the cycle after the offending acceptance edge.

## Test plan
- Reset then frame 0x11,0x22,0x33,0x44 (sof on first), `out_ready`=1 -> `out_lane0..3`=0x11/0x22/0x33/0x44, `out_valid` high exactly 1 cycle after the 4th beat edge, `in_ready` constantly 1.
- Three back-to-back frames (0x0A..0x0D, 0x1A..0x1D, 0x2A..0x2D) with continuous `in_valid`, `out_ready`=1 -> three completions 4 cycles apart, no stall, no `frame_err`/`drop`.
- `out_ready`=0 with frame A done, then frame B beats 0..3 -> `in_ready` falls only at B slot 3 and `out_lane*` holds A. Raising `out_ready` accepts B slot 3 on the same edge that A is consumed, and `out_valid` stays 1 with B data.
- Beats 0x01,0x02 with sof on first, then sof beat 0x50 followed by 0x51,0x52,0x53 -> one `frame_err` pulse, output frame 0x50/0x51/0x52/0x53, no trace of 0x01/0x02.
- Two non-sof beats in HUNT, then a sof frame -> two `drop` pulses and the sof frame completes normally.
- `rst_n` pulsed low after slot 2 of a frame, with an unconsumed frame pending -> all outputs 0 immediately (asynchronous). After release, a fresh sof frame completes correctly.

Source files
------------

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux4
//  Purpose  : Four-lane time-division demultiplexer. Collects a stream of
//             beats (slot 0 flagged by in_sof) into four parallel lane
//             registers and presents each complete frame with a valid/ready
//             handshake. Partial frames aborted by an early in_sof raise
//             frame_err; non-sof beats seen while hunting raise drop.
//  Ports    : clk, rst_n             - clock, async active-low reset
//             in_valid/in_sof/in_data/in_ready - beat input handshake
//             out_lane0..3/out_valid/out_ready - frame output handshake
//             frame_err, drop        - one-cycle registered event pulses
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_lane0,
  output logic [WIDTH-1:0] out_lane1,
  output logic [WIDTH-1:0] out_lane2,
  output logic [WIDTH-1:0] out_lane3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             drop
);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] stage0_q, stage0_d;
  logic [WIDTH-1:0] stage1_q, stage1_d;
  logic [WIDTH-1:0] stage2_q, stage2_d;
  logic [WIDTH-1:0] lane0_q, lane0_d;
  logic [WIDTH-1:0] lane1_q, lane1_d;
  logic [WIDTH-1:0] lane2_q, lane2_d;
  logic [WIDTH-1:0] lane3_q, lane3_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             drop_q, drop_d;

  logic             accept;
  logic             consume;
  logic             complete;

  // Only the slot-3 beat can be stalled: it is the one that overwrites the
  // output registers, so it must wait while an unconsumed frame sits there.
  assign in_ready = !((state_q == COLLECT) && (slot_q == 2'd3) &&
                      out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    stage0_d    = stage0_q;
    stage1_d    = stage1_q;
    stage2_d    = stage2_q;
    lane0_d     = lane0_q;
    lane1_d     = lane1_q;
    lane2_d     = lane2_q;
    lane3_d     = lane3_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    drop_d      = 1'b0;
    complete    = 1'b0;

    if (accept) begin
      case (state_q)
        HUNT: begin
          if (in_sof) begin
            stage0_d = in_data;
            slot_d   = 2'd1;
            state_d  = COLLECT;
          end else begin
            drop_d = 1'b1;
          end
        end
        COLLECT: begin
          if (in_sof) begin
            // Early sof: abandon the partial frame and restart from this beat.
            frame_err_d = 1'b1;
            stage0_d    = in_data;
            slot_d      = 2'd1;
          end else begin
            case (slot_q)
              2'd3: begin
                complete = 1'b1;
                slot_d   = 2'd0;
                state_d  = HUNT;
              end
              2'd2: begin
                stage2_d = in_data;
                slot_d   = 2'd3;
              end
              default: begin
                stage1_d = in_data;
                slot_d   = 2'd2;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Completion wins over consume so a same-edge consume/complete keeps
    // out_valid high with the new frame.
    if (complete) begin
      lane0_d     = stage0_q;
      lane1_d     = stage1_q;
      lane2_d     = stage2_q;
      lane3_d     = in_data;
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= 2'd0;
      stage0_q    <= '0;
      stage1_q    <= '0;
      stage2_q    <= '0;
      lane0_q     <= '0;
      lane1_q     <= '0;
      lane2_q     <= '0;
      lane3_q     <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      stage0_q    <= stage0_d;
      stage1_q    <= stage1_d;
      stage2_q    <= stage2_d;
      lane0_q     <= lane0_d;
      lane1_q     <= lane1_d;
      lane2_q     <= lane2_d;
      lane3_q     <= lane3_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      drop_q      <= drop_d;
    end
  end

  assign out_lane0 = lane0_q;
  assign out_lane1 = lane1_q;
  assign out_lane2 = lane2_q;
  assign out_lane3 = lane3_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign drop      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux4
//  Purpose  : Self-checking bench for tdm_demux4. A queue-based frame model
//             predicts in_ready, lane outputs, out_valid and the event pulses
//             for directed scenarios followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_sof;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] out_lane0, out_lane1, out_lane2, out_lane3;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic             drop;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_lane0 (out_lane0),
    .out_lane1 (out_lane1),
    .out_lane2 (out_lane2),
    .out_lane3 (out_lane3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: beats of the frame in progress, the held output frame
  // and the pulses produced by the most recent edge.
  logic [WIDTH-1:0] m_part[$];
  logic [WIDTH-1:0] m_lane[4];
  logic             m_ov;
  logic             m_err;
  logic             m_drop;

  function automatic logic model_ready(input logic ordy);
    return !(m_part.size() == 3 && m_ov && !ordy);
  endfunction

  task automatic model_reset();
    m_part.delete();
    for (int i = 0; i < 4; i++) m_lane[i] = '0;
    m_ov   = 1'b0;
    m_err  = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                            input logic ordy);
    logic acc, cons, done;
    acc    = v && model_ready(ordy);
    cons   = m_ov && ordy;
    done   = 1'b0;
    m_err  = 1'b0;
    m_drop = 1'b0;
    if (acc) begin
      if (m_part.size() == 0) begin
        if (s) m_part.push_back(d);
        else   m_drop = 1'b1;
      end else if (s) begin
        m_err = 1'b1;
        m_part.delete();
        m_part.push_back(d);
      end else begin
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          for (int i = 0; i < 4; i++) m_lane[i] = m_part[i];
          m_part.delete();
          done = 1'b1;
        end
      end
    end
    if (done)      m_ov = 1'b1;
    else if (cons) m_ov = 1'b0;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, m_ov);
    check("out_lane0", out_lane0, m_lane[0]);
    check("out_lane1", out_lane1, m_lane[1]);
    check("out_lane2", out_lane2, m_lane[2]);
    check("out_lane3", out_lane3, m_lane[3]);
    check("frame_err", frame_err, m_err);
    check("drop",      drop,      m_drop);
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic beat(input logic v, input logic s, input logic [WIDTH-1:0] d,
                      input logic ordy);
    in_valid  = v;
    in_sof    = s;
    in_data   = d;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, model_ready(ordy));
    @(posedge clk);
    model_step(v, s, d, ordy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic frame(input logic [WIDTH-1:0] b0, b1, b2, b3, input logic ordy);
    beat(1'b1, 1'b1, b0, ordy);
    beat(1'b1, 1'b0, b1, ordy);
    beat(1'b1, 1'b0, b2, ordy);
    beat(1'b1, 1'b0, b3, ordy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check_outputs();
    rst_n = 1'b1;

    // Single frame with out_ready held high.
    frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    beat(1'b0, 1'b0, 8'h00, 1'b1);

    // Three back-to-back frames.
    frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1);
    frame(8'h1A, 8'h1B, 8'h1C, 8'h1D, 1'b1);
    frame(8'h2A, 8'h2B, 8'h2C, 8'h2D, 1'b1);
    beat(1'b0, 1'b0, 8'h00, 1'b1);

    // Backpressure: frame A held, frame B slot 3 stalls, then released.
    frame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0);
    beat(1'b1, 1'b1, 8'hB0, 1'b0);
    beat(1'b1, 1'b0, 8'hB1, 1'b0);
    beat(1'b1, 1'b0, 8'hB2, 1'b0);
    beat(1'b1, 1'b0, 8'hB3, 1'b0);
    beat(1'b1, 1'b0, 8'hB3, 1'b0);
    beat(1'b1, 1'b0, 8'hB3, 1'b1);
    beat(1'b0, 1'b0, 8'h00, 1'b1);

    // Early sof aborts a partial frame.
    beat(1'b1, 1'b1, 8'h01, 1'b1);
    beat(1'b1, 1'b0, 8'h02, 1'b1);
    frame(8'h50, 8'h51, 8'h52, 8'h53, 1'b1);
    beat(1'b0, 1'b0, 8'h00, 1'b1);

    // Non-sof beats while hunting are dropped.
    beat(1'b1, 1'b0, 8'h77, 1'b1);
    beat(1'b1, 1'b0, 8'h78, 1'b1);
    frame(8'h61, 8'h62, 8'h63, 8'h64, 1'b1);

    // Asynchronous reset mid-frame with an unconsumed frame pending.
    frame(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b0);
    beat(1'b1, 1'b1, 8'hD0, 1'b0);
    beat(1'b1, 1'b0, 8'hD1, 1'b0);
    beat(1'b1, 1'b0, 8'hD2, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check("async_rst_in_ready", in_ready, 1'b1);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    frame(8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b1);
    beat(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic: mostly well-formed frames with occasional faults.
    for (int n = 0; n < 600; n++) begin
      logic v, s, r;
      v = ($urandom_range(0, 9) < 8);
      if (m_part.size() == 0) s = ($urandom_range(0, 9) < 8);
      else                    s = ($urandom_range(0, 9) < 1);
      r = ($urandom_range(0, 9) < 6);
      beat(v, s, WIDTH'($urandom), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
